// File: rtl/timestamp_mem_responder.sv
// rtl/timestamp_mem_responder.sv - dual-port (x,y) timestamp surface with power-on clear sweep
// Port 1 reads/writes, port 2 reads only; out-of-range coordinates read as zero and never write.
module timestamp_mem_responder #(
   parameter int DVS_WIDTH       = 346,
   parameter int DVS_HEIGHT      = 260,
   parameter int WORD_SIZE       = 18,
   parameter int CAVIAR_X_Y_BITS = 9
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cen,
   input  logic                       rw,
   input  logic [CAVIAR_X_Y_BITS-1:0] addr_port1_x,
   input  logic [CAVIAR_X_Y_BITS-1:0] addr_port1_y,
   input  logic [CAVIAR_X_Y_BITS-1:0] addr_port2_x,
   input  logic [CAVIAR_X_Y_BITS-1:0] addr_port2_y,
   input  logic [WORD_SIZE-1:0]       write_data_mem,
   output logic [WORD_SIZE-1:0]       read_data1_mem,
   output logic [WORD_SIZE-1:0]       read_data2_mem,
   output logic                       read_data_mem_vld1,
   output logic                       read_data_mem_vld2,
   output logic                       ready
);

   localparam int DEPTH = DVS_WIDTH * DVS_HEIGHT;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CMP_W = CAVIAR_X_Y_BITS + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic [CMP_W-1:0] X_LIM    = CMP_W'(DVS_WIDTH);
   localparam logic [CMP_W-1:0] Y_LIM    = CMP_W'(DVS_HEIGHT);

   typedef enum logic {
      ST_CLEAR,
      ST_READY
   } state_e;

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     clr_ptr_q, clr_ptr_d;
   logic [WORD_SIZE-1:0] mem [DEPTH];

   logic                 in_range1, in_range2;
   logic [IDX_W-1:0]     idx1, idx2;
   logic                 rd_req;
   logic                 mem_we;
   logic [IDX_W-1:0]     mem_waddr;
   logic [WORD_SIZE-1:0] mem_wdata;

   logic [WORD_SIZE-1:0] rd_data1_q, rd_data2_q;
   logic                 rd_vld1_q, rd_vld2_q;

   // Index is only meaningful when in range; wider garbage from wrapped coordinates is masked below.
   assign in_range1 = ({1'b0, addr_port1_x} < X_LIM) && ({1'b0, addr_port1_y} < Y_LIM);
   assign in_range2 = ({1'b0, addr_port2_x} < X_LIM) && ({1'b0, addr_port2_y} < Y_LIM);
   assign idx1 = IDX_W'(addr_port1_y) * IDX_W'(DVS_WIDTH) + IDX_W'(addr_port1_x);
   assign idx2 = IDX_W'(addr_port2_y) * IDX_W'(DVS_WIDTH) + IDX_W'(addr_port2_x);

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      rd_req    = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = idx1;
      mem_wdata = write_data_mem;
      case (state_q)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wdata = '0;
            if (clr_ptr_q == LAST_IDX) begin
               state_d = ST_READY;
            end else begin
               clr_ptr_d = clr_ptr_q + IDX_W'(1);
            end
         end
         ST_READY: begin
            rd_req = cen && !rw;
            mem_we = cen && rw && in_range1;
         end
         default: begin
            state_d = ST_CLEAR;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_CLEAR;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   // Storage has no reset; the clear sweep initialises it.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld1_q  <= 1'b0;
         rd_vld2_q  <= 1'b0;
         rd_data1_q <= '0;
         rd_data2_q <= '0;
      end else begin
         rd_vld1_q <= rd_req;
         rd_vld2_q <= rd_req;
         if (rd_req) begin
            rd_data1_q <= in_range1 ? mem[idx1] : '0;
            rd_data2_q <= in_range2 ? mem[idx2] : '0;
         end
      end
   end

   assign read_data1_mem     = rd_data1_q;
   assign read_data2_mem     = rd_data2_q;
   assign read_data_mem_vld1 = rd_vld1_q;
   assign read_data_mem_vld2 = rd_vld2_q;
   assign ready              = (state_q == ST_READY);

endmodule

// File: tb/tb_timestamp_mem_responder.sv
// tb/tb_timestamp_mem_responder.sv - randomized self-checking bench with behavioural surface model
module tb_timestamp_mem_responder;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int WS = 18;
   localparam int XB = 9;
   localparam int N  = W * H;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cen, rw;
   logic [XB-1:0] p1x, p1y, p2x, p2y;
   logic [WS-1:0] wdata;
   logic [WS-1:0] rd1, rd2;
   logic          vld1, vld2, rdy;

   int errors = 0;
   int checks = 0;

   logic [WS-1:0] ref_mem [N];
   logic [WS-1:0] exp_d1, exp_d2;

   always #5 clk = ~clk;

   timestamp_mem_responder #(
      .DVS_WIDTH(W), .DVS_HEIGHT(H), .WORD_SIZE(WS), .CAVIAR_X_Y_BITS(XB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .rw(rw),
      .addr_port1_x(p1x), .addr_port1_y(p1y),
      .addr_port2_x(p2x), .addr_port2_y(p2y),
      .write_data_mem(wdata),
      .read_data1_mem(rd1), .read_data2_mem(rd2),
      .read_data_mem_vld1(vld1), .read_data_mem_vld2(vld2),
      .ready(rdy)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [WS-1:0] model_rd(input logic [XB-1:0] x, input logic [XB-1:0] y);
      if (x < W && y < H) return ref_mem[y * W + x];
      return '0;
   endfunction

   // Called at posedge+1; returns at the following posedge+1 after checking outputs.
   task automatic do_req(input bit c, input bit r,
                         input logic [XB-1:0] x1, input logic [XB-1:0] y1,
                         input logic [XB-1:0] x2, input logic [XB-1:0] y2,
                         input logic [WS-1:0] wd, input string tag);
      bit exp_vld;
      cen = c; rw = r; p1x = x1; p1y = y1; p2x = x2; p2y = y2; wdata = wd;
      exp_vld = c && !r;
      if (exp_vld) begin
         exp_d1 = model_rd(x1, y1);
         exp_d2 = model_rd(x2, y2);
      end
      @(posedge clk);
      if (c && r && x1 < W && y1 < H) ref_mem[y1 * W + x1] = wd;
      #1;
      check_eq({tag, ".vld1"}, 32'(vld1), 32'(exp_vld));
      check_eq({tag, ".vld2"}, 32'(vld2), 32'(exp_vld));
      check_eq({tag, ".d1"}, 32'(rd1), 32'(exp_d1));
      check_eq({tag, ".d2"}, 32'(rd2), 32'(exp_d2));
      cen = 1'b0;
   endtask

   task automatic readback_all(input string tag);
      for (int i = 0; i < N; i++) begin
         do_req(1'b1, 1'b0, XB'(i % W), XB'(i / W), XB'((N - 1 - i) % W), XB'((N - 1 - i) / W), '0, tag);
      end
   endtask

   // Asserts reset at posedge+1, checks immediate clearing, then follows the sweep edge by edge.
   task automatic do_reset(input bit poke_during_clear);
      rst_n = 1'b0;
      #1;
      check_eq("rst.vld1", 32'(vld1), 0);
      check_eq("rst.vld2", 32'(vld2), 0);
      check_eq("rst.d1", 32'(rd1), 0);
      check_eq("rst.d2", 32'(rd2), 0);
      check_eq("rst.ready", 32'(rdy), 0);
      for (int i = 0; i < N; i++) ref_mem[i] = '0;
      exp_d1 = '0;
      exp_d2 = '0;
      cen = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 1; k <= N; k++) begin
         cen = 1'b0;
         if (poke_during_clear && k == 5) begin
            cen = 1'b1; rw = 1'b1; p1x = '0; p1y = '0; wdata = 18'h3FFFF;
         end
         if (poke_during_clear && k == 6) begin
            cen = 1'b1; rw = 1'b0; p1x = '0; p1y = '0; p2x = '0; p2y = '0;
         end
         @(posedge clk);
         #1;
         check_eq($sformatf("clr.ready%0d", k), 32'(rdy), 32'(k == N));
         check_eq($sformatf("clr.vld%0d", k), 32'({vld1, vld2}), 0);
      end
      cen = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; cen = 1'b0; rw = 1'b0;
      p1x = '0; p1y = '0; p2x = '0; p2y = '0; wdata = '0;
      exp_d1 = '0; exp_d2 = '0;
      repeat (2) @(posedge clk);
      #1;
      do_reset(1'b1);
      readback_all("init");

      do_req(1'b1, 1'b1, 9'd1, 9'd2, 9'd0, 9'd0, 18'h0ABCD, "wr12");
      do_req(1'b1, 1'b0, 9'd1, 9'd2, 9'd0, 9'd0, '0, "rd12");
      check_eq("rd12.direct", 32'(rd1), 32'h0ABCD);

      do_req(1'b1, 1'b1, 9'h1FF, 9'd0, 9'd0, 9'd0, 18'h11111, "oorx");
      do_req(1'b1, 1'b1, 9'd0, 9'd3, 9'd0, 9'd0, 18'h22222, "oory");
      do_req(1'b1, 1'b1, 9'd3, 9'h1FF, 9'd0, 9'd0, 18'h33333, "oorxy");
      readback_all("oor_rb");
      do_req(1'b1, 1'b0, 9'h1FF, 9'd2, 9'd1, 9'd3, '0, "oor_rd");

      for (int i = 0; i < 400; i++) begin
         logic [XB-1:0] ax, ay, bx, by;
         ax = ($urandom_range(0, 9) == 0) ? 9'h1FF : XB'($urandom_range(0, W));
         ay = XB'($urandom_range(0, H));
         bx = ($urandom_range(0, 9) == 0) ? 9'h1FF : XB'($urandom_range(0, W));
         by = XB'($urandom_range(0, H));
         do_req($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ax, ay, bx, by,
                WS'($urandom), "rand");
      end

      for (int i = 0; i < N; i++) begin
         do_req(1'b1, 1'b1, XB'(i % W), XB'(i / W), '0, '0, WS'(18'h100 + i * 7), "fill");
      end
      for (int i = 0; i < 8; i++) begin
         do_req(1'b1, 1'b0, XB'((i * 5) % W), XB'(((i * 5) % N) / W), XB'(i % W), XB'(i / W),
                '0, $sformatf("b2b%0d", i));
      end

      for (int i = 0; i < 3; i++) begin
         do_req(1'b1, 1'b0, XB'(i), 9'd1, 9'd2, 9'd2, '0, "burst");
      end
      cen = 1'b1; rw = 1'b0;
      do_reset(1'b0);
      readback_all("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
